hearts_lives_ctrl: RTL and testbench

//  Upstream stage of the heart bitmap: tracks player lives and, per VGA pixel, decides whether the pixel

---
 rtl/hud_pkg.sv | 16 +
 rtl/hud_slot_locator.sv | 44 ++++
 rtl/hearts_lives_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hearts_lives_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared HUD layout constants and the lives state type used by the HUD blocks.
package hud_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        BLINK = 2'd1,
        DEAD  = 2'd2
    } lives_state_t;

    localparam int unsigned HUD_PIX_W      = 11;
    localparam int unsigned HUD_TOP_LEFT_X = 16;
    localparam int unsigned HUD_TOP_LEFT_Y = 8;
    localparam int unsigned HUD_HEART_SIZE = 32;
    localparam int unsigned HUD_SPACING    = 36;

endpackage

// File: rtl/hud_slot_locator.sv
// Maps a scan pixel onto a row of equally pitched HUD slots: slot index,
// slot-local offsets and an in-slot flag. Purely combinational.
module hud_slot_locator #(
    parameter int unsigned MAX_LIVES  = 3,
    parameter int unsigned TOP_LEFT_X = 16,
    parameter int unsigned TOP_LEFT_Y = 8,
    parameter int unsigned HEART_SIZE = 32,
    parameter int unsigned SPACING    = 36
) (
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic [2:0]  slot,
    output logic [10:0] local_x,
    output logic [10:0] local_y,
    output logic        in_slot
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic        x_ok;
    logic        y_ok;
    logic        found;

    // Slot search by ascending compare chain against slot boundaries (no divider).
    always_comb begin
        dx      = pixel_x - 11'(TOP_LEFT_X);
        dy      = pixel_y - 11'(TOP_LEFT_Y);
        x_ok    = (pixel_x >= 11'(TOP_LEFT_X));
        y_ok    = (pixel_y >= 11'(TOP_LEFT_Y)) && (dy < 11'(HEART_SIZE));
        slot    = '0;
        local_x = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_LIVES; k++) begin
            if (!found && (dx < 11'((k + 1) * SPACING))) begin
                found   = 1'b1;
                slot    = 3'(k);
                local_x = dx - 11'(k * SPACING);
            end
        end
        local_y = dy;
        in_slot = x_ok && y_ok && found && (local_x < 11'(HEART_SIZE));
    end

endmodule

// File: rtl/hearts_lives_ctrl.sv
// Player lives tracker and heart-row HUD pixel locator. A lost heart blinks
// for a number of frames before disappearing; game over follows at zero lives.
module hearts_lives_ctrl
    import hud_pkg::*;
#(
    parameter int unsigned MAX_LIVES    = 3,
    parameter int unsigned INIT_LIVES   = 3,
    parameter int unsigned TOP_LEFT_X   = HUD_TOP_LEFT_X,
    parameter int unsigned TOP_LEFT_Y   = HUD_TOP_LEFT_Y,
    parameter int unsigned HEART_SIZE   = HUD_HEART_SIZE,
    parameter int unsigned SPACING      = HUD_SPACING,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        hit,
    input  logic        bonus,
    input  logic        restart,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [2:0]  lives,
    output logic        game_over
);

    localparam int unsigned FC_W = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned PC_W = $clog2(BLINK_PERIOD + 1);

    lives_state_t    state;
    lives_state_t    state_n;
    logic [2:0]      lives_q;
    logic [2:0]      lives_n;
    logic [FC_W-1:0] frame_cnt;
    logic [FC_W-1:0] frame_n;
    logic [PC_W-1:0] period_cnt;
    logic [PC_W-1:0] period_n;
    logic            blink_vis;
    logic            vis_n;

    logic [2:0]      slot;
    logic [10:0]     local_x;
    logic [10:0]     local_y;
    logic            in_slot;
    logic            slot_visible;

    hud_slot_locator #(
        .MAX_LIVES  (MAX_LIVES),
        .TOP_LEFT_X (TOP_LEFT_X),
        .TOP_LEFT_Y (TOP_LEFT_Y),
        .HEART_SIZE (HEART_SIZE),
        .SPACING    (SPACING)
    ) u_locator (
        .pixel_x (pixelX),
        .pixel_y (pixelY),
        .slot    (slot),
        .local_x (local_x),
        .local_y (local_y),
        .in_slot (in_slot)
    );

    // Next-state logic for the lives FSM, lives counter and blink counters.
    // Blink counters only advance on startOfFrame so visibility never changes mid-frame;
    // BLINK is entered with the lost heart visible, so the immediate lives drop does not tear.
    always_comb begin
        state_n  = state;
        lives_n  = lives_q;
        frame_n  = frame_cnt;
        period_n = period_cnt;
        vis_n    = blink_vis;
        if (restart) begin
            state_n  = ALIVE;
            lives_n  = 3'(INIT_LIVES);
            frame_n  = '0;
            period_n = '0;
            vis_n    = 1'b1;
        end else begin
            case (state)
                ALIVE: begin
                    if (hit && !bonus && (lives_q != 3'd0)) begin
                        state_n  = BLINK;
                        lives_n  = lives_q - 3'd1;
                        frame_n  = '0;
                        period_n = '0;
                        vis_n    = 1'b1;
                    end else if (bonus && !hit && (lives_q < 3'(MAX_LIVES))) begin
                        lives_n = lives_q + 3'd1;
                    end
                end
                BLINK: begin
                    if (bonus && (lives_q < 3'(MAX_LIVES))) begin
                        lives_n = lives_q + 3'd1;
                    end
                    if (startOfFrame) begin
                        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                            state_n  = (lives_n != 3'd0) ? ALIVE : DEAD;
                            frame_n  = '0;
                            period_n = '0;
                            vis_n    = 1'b1;
                        end else begin
                            frame_n = frame_cnt + FC_W'(1);
                            if (period_cnt == PC_W'(BLINK_PERIOD - 1)) begin
                                period_n = '0;
                                vis_n    = !blink_vis;
                            end else begin
                                period_n = period_cnt + PC_W'(1);
                            end
                        end
                    end
                end
                DEAD: begin
                    state_n = DEAD;
                end
                default: begin
                    state_n = ALIVE;
                end
            endcase
        end
    end

    // Control state registers; game_over tracks the DEAD state cycle-for-cycle.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= ALIVE;
            lives_q    <= 3'(INIT_LIVES);
            frame_cnt  <= '0;
            period_cnt <= '0;
            blink_vis  <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            lives_q    <= lives_n;
            frame_cnt  <= frame_n;
            period_cnt <= period_n;
            blink_vis  <= vis_n;
            game_over  <= (state_n == DEAD);
        end
    end

    // A slot is drawn when it holds a life, or it is the heart being lost and in its visible phase.
    always_comb begin
        slot_visible = (slot < lives_q) ||
                       ((state == BLINK) && blink_vis && (slot == lives_q));
    end

    // Registered pixel outputs: one cycle behind the scan coordinates.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= in_slot && slot_visible;
            offsetX         <= (in_slot && slot_visible) ? local_x : '0;
            offsetY         <= (in_slot && slot_visible) ? local_y : '0;
        end
    end

    assign lives = lives_q;

endmodule

// File: tb/tb_hearts_lives_ctrl.sv
// Scoreboard bench for hearts_lives_ctrl: stimulus queues expected responses,
// a monitor compares them when the registered response is due.
module tb_hearts_lives_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        hit = 1'b0;
    logic        bonus = 1'b0;
    logic        restart = 1'b0;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [2:0]  lives;
    logic        game_over;

    typedef struct packed {
        logic        ins;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [2:0]  lv;
        logic        go;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  req = 1'b0;
    logic  req_d = 1'b0;
    int    passed = 0;
    int    total = 0;

    always #5 clk = ~clk;

    hearts_lives_ctrl #(
        .MAX_LIVES    (3),
        .INIT_LIVES   (3),
        .TOP_LEFT_X   (16),
        .TOP_LEFT_Y   (8),
        .HEART_SIZE   (32),
        .SPACING      (36),
        .BLINK_FRAMES (60),
        .BLINK_PERIOD (8)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .hit             (hit),
        .bonus           (bonus),
        .restart         (restart),
        .InsideRectangle (InsideRectangle),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .lives           (lives),
        .game_over       (game_over)
    );

    // Response is due one clock after the request was presented.
    always @(posedge clk) req_d <= req;

    // Monitor: pop and compare whenever a response is due.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (req_d) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL monitor: response due but scoreboard empty");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({InsideRectangle, offsetX, offsetY, lives, game_over} === e) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got ins=%0d ox=%0d oy=%0d lives=%0d go=%0d, expected ins=%0d ox=%0d oy=%0d lives=%0d go=%0d",
                             nm, InsideRectangle, offsetX, offsetY, lives, game_over,
                             e.ins, e.ox, e.oy, e.lv, e.go);
                end
            end
        end
    end

    task automatic chk(input logic [10:0] x, input logic [10:0] y, input logic ins,
                       input logic [10:0] ox, input logic [10:0] oy,
                       input logic [2:0] lv, input logic go, input string nm);
        exp_t e;
        e.ins = ins; e.ox = ox; e.oy = oy; e.lv = lv; e.go = go;
        pixelX = x;
        pixelY = y;
        exp_q.push_back(e);
        name_q.push_back(nm);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        pixelX = '0;
        pixelY = '0;
    endtask

    task automatic do_hit();
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic do_bonus();
        bonus = 1'b1;
        @(negedge clk);
        bonus = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v;
        @(negedge clk);
        @(negedge clk);
        // Reset state
        chk(16, 8, 0, 0, 0, 3, 0, "reset");
        resetN = 1'b1;

        // Geometry with three lives
        chk(16, 8, 1, 0, 0, 3, 0, "slot0_origin");
        chk(47, 39, 1, 31, 31, 3, 0, "slot0_corner");
        chk(48, 8, 0, 0, 0, 3, 0, "gap_48");
        chk(88, 20, 1, 0, 12, 3, 0, "slot2_mid");
        chk(15, 8, 0, 0, 0, 3, 0, "left_of_origin");
        chk(16, 7, 0, 0, 0, 3, 0, "above_origin");
        chk(16, 40, 0, 0, 0, 3, 0, "below_slot");
        chk(120, 8, 0, 0, 0, 3, 0, "slot2_right_edge");
        chk(124, 8, 0, 0, 0, 3, 0, "slot3_absent");

        // First hit and blink of slot 2
        do_hit();
        chk(88, 8, 1, 0, 0, 2, 0, "blink_f0");
        for (int f = 1; f <= 60; f++) begin
            frame();
            if (f == 20) begin
                do_hit();
                chk(0, 0, 0, 0, 0, 2, 0, "hit_immune");
            end
            if (f == 7 || f == 8 || f == 15 || f == 16 || f == 55 || f == 56 || f == 59) begin
                v = (((f / 8) % 2) == 0);
                chk(88, 8, v, 0, 0, 2, 0, $sformatf("blink_f%0d", f));
            end
        end
        chk(88, 8, 0, 0, 0, 2, 0, "blink_end_slot2_gone");
        chk(52, 8, 1, 0, 0, 2, 0, "slot1_solid");

        // Hit after window, then final life
        do_hit();
        chk(52, 8, 1, 0, 0, 1, 0, "hit2_blink");
        frames(60);
        chk(52, 8, 0, 0, 0, 1, 0, "hit2_end");
        do_hit();
        chk(16, 8, 1, 0, 0, 0, 0, "hit3_blink");
        frames(59);
        chk(0, 0, 0, 0, 0, 0, 0, "go_low_f59");
        frame();
        chk(0, 0, 0, 0, 0, 0, 1, "go_rise");
        chk(16, 8, 0, 0, 0, 0, 1, "dead_slot0_off");
        do_bonus();
        chk(0, 0, 0, 0, 0, 0, 1, "bonus_in_dead");
        do_restart();
        chk(88, 8, 1, 0, 0, 3, 0, "restart");

        // Bonus saturation, hit+bonus in ALIVE, restart priority
        do_bonus();
        chk(0, 0, 0, 0, 0, 3, 0, "bonus_sat");
        do_hit();
        frames(60);
        chk(88, 8, 0, 0, 0, 2, 0, "lives2_alive");
        hit = 1'b1; bonus = 1'b1;
        @(negedge clk);
        hit = 1'b0; bonus = 1'b0;
        chk(88, 8, 0, 0, 0, 2, 0, "hit_bonus_alive");
        chk(52, 8, 1, 0, 0, 2, 0, "hit_bonus_slot1");
        do_bonus();
        chk(88, 8, 1, 0, 0, 3, 0, "bonus_alive");
        do_hit();
        frames(60);
        restart = 1'b1; hit = 1'b1;
        @(negedge clk);
        restart = 1'b0; hit = 1'b0;
        chk(88, 8, 1, 0, 0, 3, 0, "restart_prio");

        // Reset in the middle of a blink at one life
        do_hit();
        frames(60);
        do_hit();
        frames(3);
        chk(52, 8, 1, 0, 0, 1, 0, "pre_reset_blink");
        resetN = 1'b0;
        chk(16, 8, 0, 0, 0, 3, 0, "reset_mid_blink");
        resetN = 1'b1;
        frame();
        chk(16, 8, 1, 0, 0, 3, 0, "after_reset_slot0");
        chk(60, 10, 1, 8, 2, 3, 0, "after_reset_slot1");
        chk(100, 39, 1, 12, 31, 3, 0, "after_reset_slot2");

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d responses never arrived, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
